fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that sequences the 8-bit program counter of the core. Each cycle it decides whether the PC holds, increments, takes a relative branch or restarts at zero. The decision covers start/halt, multi-cycle load stalls and branch resolution (blt/bne on the ALU compare result). It sits between decode/ALU and the PC register and drives the PC's next-value select.

## Interface
- `LOAD_LAT`, default 2: total cycles a load instruction occupies fetch; legal range 1..8; 1 means no stall.
- `clk  input  1`: sole clock; all state updates on posedge.
- `reset  input  1`: synchronous, active-low (0 = reset), sampled on posedge `clk`.
- `start  input  1`: begin or restart program execution from PC 0; meaningful in IDLE and HALTED.
- `halt_instr  input  1`: current instruction is a halt.
- `is_load  input  1`: current instruction is a load.
- `branchsig  input  1`: current instruction is a branch.
- `branchtype  input  1`: 0 = blt (taken if cmp < 0, signed); 1 = bne (taken if cmp != 0).
- `cmp  input  8`: signed compare result from the ALU.
- `pc_sel  output  2`: next-PC select to the PC mux: HOLD=0, INC=1, BRANCH=2 (PC + branch offset, mod 256), ZERO=3.
- `running  output  1`: high in RUN and STALL.
- `done  output  1`: registered; high while in HALTED.
- `instr_count  output  16`: retired-instruction count; present only with the configuration macro.

## Operation
- States: IDLE, RUN, STALL, HALTED; plus `stall_cnt`, 3 bits.
- `pc_sel` is combinational from state and inputs (Mealy), so the PC updates on the same edge the decision is made.
- **IDLE**
  - `pc_sel`=HOLD.
  - `start`=1 → `pc_sel`=ZERO, next state RUN.
- **RUN**, priority halt > load > branch > normal:
  - `halt_instr` → HOLD, next HALTED.
  - `is_load` with `LOAD_LAT`>1 → HOLD, `stall_cnt`←`LOAD_LAT`-2, next STALL.
  - `is_load` with `LOAD_LAT`=1 → INC.
  - `branchsig` → BRANCH if taken, else INC.
  - Otherwise → INC.
  - `start` is ignored in RUN.
- **STALL**
  - All instruction inputs are ignored.
  - `stall_cnt`=0 → INC, next RUN.
  - Otherwise → HOLD, `stall_cnt` decrements.
- **HALTED**
  - `pc_sel`=HOLD.
  - `start`=1 → ZERO, next RUN.
- Branch taken:
  - branchtype=0: `$signed(cmp)` < 0, i.e. cmp[7]=1.
  - branchtype=1: cmp != 8'h00.
  - Only `cmp` is evaluated; offset addition and wrap-around are the PC's responsibility.

## Timing
- Reset (`reset`=0 at an edge) applies regardless of state, including mid-stall. Next cycle:
  - state = IDLE, `stall_cnt` = 0, `done` = 0, `running` = 0, `instr_count` = 0.
  - `pc_sel` = HOLD.
- A load occupies exactly `LOAD_LAT` cycles: one RUN cycle plus `LOAD_LAT`-1 STALL cycles; INC is issued on the last of them.
- Branch, normal and halt instructions occupy 1 cycle.
- `done` rises the cycle after the halt instruction is seen and falls the cycle after `start` in HALTED.
- `running` is registered from state, so it lags `pc_sel` decisions by zero cycles relative to state.

## Configuration
- Macro `FETCH_SEQ_INSTR_COUNT_EN`.
- With the macro defined:
  - `instr_count` exists and increments on every cycle where `pc_sel` is INC or BRANCH.
  - It saturates at 16'hFFFF.
  - It clears to 0 on the cycle `start` is accepted (the ZERO issue).
  - It holds in HALTED.
- Without the macro: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - `pc_sel_t` enum (HOLD/INC/BRANCH/ZERO, 2 bits).
  - `fseq_state_t` enum.
  - `PC_W`=8 and `CNT_W`=16 constants.
- One sub-module, `branch_resolve`: combinational; inputs `branchtype`, `cmp`; output `taken`. Reused by any later branch predictor.

## Test plan
- Reset with `reset`=0 for 2 cycles mid-STALL (`LOAD_LAT`=4) → IDLE, HOLD, `done`=0, counter 0 next cycle.
- `start` in IDLE, then 3 plain instructions → `pc_sel` sequence ZERO, INC, INC, INC; `instr_count`=3.
- `LOAD_LAT`=3, `is_load`=1 in RUN → HOLD, HOLD, INC over 3 cycles; `is_load` toggling during STALL has no effect.
- Branch with branchtype=0:
  - cmp=8'h80 → BRANCH.
  - cmp=8'h7F → INC.
- Branch with branchtype=1:
  - cmp=8'h00 → INC.
  - cmp=8'h01 → BRANCH.
- `halt_instr`=1 with `is_load`=1 and `branchsig`=1 together → HOLD, `done`=1 next cycle; `start` in HALTED → ZERO, `done`=0; `instr_count` cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
//==============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch sequencer and any
//               later branch-related logic (PC select codes, FSM states).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_pkg;

   localparam int PC_W  = 8;
   localparam int CNT_W = 16;

   // Select code driven to the PC next-value mux
   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      INC    = 2'd1,
      BRANCH = 2'd2,
      ZERO   = 2'd3
   } pc_sel_t;

   // Fetch sequencer control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STALL  = 2'd2,
      HALTED = 2'd3
   } fseq_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/branch_resolve.sv
//==============================================================================
// Module      : branch_resolve
// Description : Combinational branch-taken decision from the ALU compare
//               result. blt: taken when cmp is negative (signed);
//               bne: taken when cmp is non-zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_resolve
   import fetch_pkg::*;
(
   input  logic            branchtype,
   input  logic [PC_W-1:0] cmp,
   output logic            taken
);

   // Sign bit alone decides blt; any set bit decides bne
   always_comb begin
      taken = 1'b0;
      if (branchtype)
         taken = (cmp != '0);
      else
         taken = cmp[PC_W-1];
   end

endmodule : branch_resolve

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//==============================================================================
// Module      : fetch_sequencer
// Description : Control FSM sequencing the 8-bit program counter. Chooses the
//               PC next-value select each cycle (hold, increment, relative
//               branch, restart at zero) from start/halt, load stalls and
//               branch resolution. pc_sel is Mealy so the PC moves on the
//               same edge the decision is made.
// Config      : FETCH_SEQ_INSTR_COUNT_EN - adds the saturating retired
//               instruction counter and its instr_count output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int LOAD_LAT = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_instr,
   input  logic             is_load,
   input  logic             branchsig,
   input  logic             branchtype,
   input  logic [PC_W-1:0]  cmp,
   output logic [1:0]       pc_sel,
   output logic             running,
   output logic             done
`ifdef FETCH_SEQ_INSTR_COUNT_EN
   ,
   output logic [CNT_W-1:0] instr_count
`endif
);

   // Stall count loaded on the RUN cycle of a load; the last STALL cycle
   // (count 0) issues the increment, giving LOAD_LAT cycles in total.
   localparam logic [2:0] STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

   fseq_state_t state;
   fseq_state_t state_nxt;
   logic [2:0]  stall_cnt;
   logic [2:0]  stall_nxt;
   pc_sel_t     sel;
   logic        taken;

   branch_resolve u_branch_resolve (
      .branchtype (branchtype),
      .cmp        (cmp),
      .taken      (taken)
   );

   assign pc_sel = sel;

   // Next-state and PC select decision; RUN priority is halt > load > branch
   always_comb begin
      sel       = HOLD;
      state_nxt = state;
      stall_nxt = stall_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               sel       = ZERO;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (halt_instr) begin
               state_nxt = HALTED;
            end else if (is_load) begin
               if (LOAD_LAT > 1) begin
                  stall_nxt = STALL_INIT;
                  state_nxt = STALL;
               end else begin
                  sel = INC;
               end
            end else if (branchsig) begin
               sel = taken ? BRANCH : INC;
            end else begin
               sel = INC;
            end
         end
         STALL: begin
            if (stall_cnt == 3'd0) begin
               sel       = INC;
               state_nxt = RUN;
            end else begin
               stall_nxt = stall_cnt - 3'd1;
            end
         end
         HALTED: begin
            if (start) begin
               sel       = ZERO;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register with status flags registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         stall_cnt <= 3'd0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_nxt;
         running   <= (state_nxt == RUN) || (state_nxt == STALL);
         done      <= (state_nxt == HALTED);
      end
   end

`ifdef FETCH_SEQ_INSTR_COUNT_EN
   // Retired-instruction counter: clears on restart, saturates at all ones
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_count <= '0;
      end else if (sel == ZERO) begin
         instr_count <= '0;
      end else if ((sel == INC || sel == BRANCH) && (instr_count != {CNT_W{1'b1}})) begin
         instr_count <= instr_count + 1'b1;
      end
   end
`endif

endmodule : fetch_sequencer

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//==============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer. Three
//               instances (LOAD_LAT 3, 4 and 1) share one stimulus stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_sequencer;

   localparam logic [1:0] S_HOLD   = 2'd0;
   localparam logic [1:0] S_INC    = 2'd1;
   localparam logic [1:0] S_BRANCH = 2'd2;
   localparam logic [1:0] S_ZERO   = 2'd3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       halt_instr = 1'b0;
   logic       is_load = 1'b0;
   logic       branchsig = 1'b0;
   logic       branchtype = 1'b0;
   logic [7:0] cmp = 8'h00;

   logic [1:0] sel3, sel4, sel1;
   logic       run3, run4, run1;
   logic       done3, done4, done1;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
   logic [15:0] cnt3, cnt4, cnt1;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.LOAD_LAT(3)) u3 (
      .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr),
      .is_load(is_load), .branchsig(branchsig), .branchtype(branchtype),
      .cmp(cmp), .pc_sel(sel3), .running(run3), .done(done3)
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      , .instr_count(cnt3)
`endif
   );

   fetch_sequencer #(.LOAD_LAT(4)) u4 (
      .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr),
      .is_load(is_load), .branchsig(branchsig), .branchtype(branchtype),
      .cmp(cmp), .pc_sel(sel4), .running(run4), .done(done4)
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      , .instr_count(cnt4)
`endif
   );

   fetch_sequencer #(.LOAD_LAT(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr),
      .is_load(is_load), .branchsig(branchsig), .branchtype(branchtype),
      .cmp(cmp), .pc_sel(sel1), .running(run1), .done(done1)
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      , .instr_count(cnt1)
`endif
   );

   // Advance one cycle; inputs change and outputs are read 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #2;
      vectors++;
      if (sel3 !== S_HOLD) begin miscompares++; $display("FAIL reset_pc_sel: got %0d want %0d", sel3, S_HOLD); end
      vectors++;
      if (done3 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done3); end
      vectors++;
      if (run3 !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b want 0", run3); end

      // Put the LOAD_LAT=4 instance into STALL, then reset it mid-stall
      start = 1'b1;
      #2;
      vectors++;
      if (sel4 !== S_ZERO) begin miscompares++; $display("FAIL l4_start_sel: got %0d want %0d", sel4, S_ZERO); end
      tick();
      start   = 1'b0;
      is_load = 1'b1;
      #2;
      vectors++;
      if (sel4 !== S_HOLD) begin miscompares++; $display("FAIL l4_load_sel: got %0d want %0d", sel4, S_HOLD); end
      tick();
      is_load = 1'b0;
      #2;
      vectors++;
      if (run4 !== 1'b1) begin miscompares++; $display("FAIL l4_stall_running: got %b want 1", run4); end
      vectors++;
      if (sel4 !== S_HOLD) begin miscompares++; $display("FAIL l4_stall_sel: got %0d want %0d", sel4, S_HOLD); end
      tick();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #2;
      vectors++;
      if (sel4 !== S_HOLD) begin miscompares++; $display("FAIL midstall_reset_sel: got %0d want %0d", sel4, S_HOLD); end
      vectors++;
      if (done4 !== 1'b0) begin miscompares++; $display("FAIL midstall_reset_done: got %b want 0", done4); end
      vectors++;
      if (run4 !== 1'b0) begin miscompares++; $display("FAIL midstall_reset_running: got %b want 0", run4); end
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt4 !== 16'd0) begin miscompares++; $display("FAIL midstall_reset_count: got %0d want 0", cnt4); end
`endif
   endtask

   task automatic test_plain();
      start = 1'b1;
      #2;
      vectors++;
      if (sel3 !== S_ZERO) begin miscompares++; $display("FAIL plain_start_sel: got %0d want %0d", sel3, S_ZERO); end
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start = (i == 2);   // start must be ignored while running
         #2;
         vectors++;
         if (sel3 !== S_INC) begin miscompares++; $display("FAIL plain_inc%0d: got %0d want %0d", i, sel3, S_INC); end
         tick();
      end
      start = 1'b0;
      vectors++;
      if (run3 !== 1'b1) begin miscompares++; $display("FAIL plain_running: got %b want 1", run3); end
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt3 !== 16'd3) begin miscompares++; $display("FAIL plain_count: got %0d want 3", cnt3); end
`endif
   endtask

   task automatic test_load();
      is_load = 1'b1;
      #2;
      vectors++;
      if (sel3 !== S_HOLD) begin miscompares++; $display("FAIL load_c0: got %0d want %0d", sel3, S_HOLD); end
      vectors++;
      if (sel1 !== S_INC) begin miscompares++; $display("FAIL load_lat1: got %0d want %0d", sel1, S_INC); end
      tick();
      is_load = 1'b0;
      #2;
      vectors++;
      if (sel3 !== S_HOLD) begin miscompares++; $display("FAIL load_c1: got %0d want %0d", sel3, S_HOLD); end
      vectors++;
      if (run3 !== 1'b1) begin miscompares++; $display("FAIL load_running: got %b want 1", run3); end
      tick();
      is_load = 1'b1;
      #2;
      vectors++;
      if (sel3 !== S_INC) begin miscompares++; $display("FAIL load_c2: got %0d want %0d", sel3, S_INC); end
      tick();
      is_load = 1'b0;
      #2;
      vectors++;
      if (sel3 !== S_INC) begin miscompares++; $display("FAIL load_after: got %0d want %0d", sel3, S_INC); end
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt3 !== 16'd4) begin miscompares++; $display("FAIL load_count: got %0d want 4", cnt3); end
`endif
   endtask

   task automatic test_branch();
      logic       bt_tab  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] cmp_tab [7] = '{8'h80, 8'h7F, 8'h00, 8'h01, 8'hFF, 8'h80, 8'h00};
      logic [1:0] exp_tab [7] = '{S_BRANCH, S_INC, S_INC, S_BRANCH, S_BRANCH, S_BRANCH, S_INC};
      branchsig = 1'b1;
      for (int i = 0; i < 7; i++) begin
         branchtype = bt_tab[i];
         cmp        = cmp_tab[i];
         #2;
         vectors++;
         if (sel3 !== exp_tab[i]) begin
            miscompares++;
            $display("FAIL branch%0d type=%b cmp=%h: got %0d want %0d", i, bt_tab[i], cmp_tab[i], sel3, exp_tab[i]);
         end
         tick();
      end
      branchsig = 1'b0;
      cmp       = 8'h00;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt3 !== 16'd11) begin miscompares++; $display("FAIL branch_count: got %0d want 11", cnt3); end
`endif
   endtask

   task automatic test_halt();
      halt_instr = 1'b1;
      is_load    = 1'b1;
      branchsig  = 1'b1;
      branchtype = 1'b1;
      cmp        = 8'h01;
      #2;
      vectors++;
      if (sel3 !== S_HOLD) begin miscompares++; $display("FAIL halt_sel: got %0d want %0d", sel3, S_HOLD); end
      tick();
      halt_instr = 1'b0;
      is_load    = 1'b0;
      branchsig  = 1'b0;
      cmp        = 8'h00;
      #2;
      vectors++;
      if (done3 !== 1'b1) begin miscompares++; $display("FAIL halt_done: got %b want 1", done3); end
      vectors++;
      if (run3 !== 1'b0) begin miscompares++; $display("FAIL halt_running: got %b want 0", run3); end
      vectors++;
      if (sel3 !== S_HOLD) begin miscompares++; $display("FAIL halted_sel: got %0d want %0d", sel3, S_HOLD); end
      tick();
      vectors++;
      if (done3 !== 1'b1) begin miscompares++; $display("FAIL halted_done_hold: got %b want 1", done3); end
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt3 !== 16'd11) begin miscompares++; $display("FAIL halted_count: got %0d want 11", cnt3); end
`endif
      start = 1'b1;
      #2;
      vectors++;
      if (sel3 !== S_ZERO) begin miscompares++; $display("FAIL restart_sel: got %0d want %0d", sel3, S_ZERO); end
      tick();
      start = 1'b0;
      #2;
      vectors++;
      if (done3 !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b want 0", done3); end
      vectors++;
      if (run3 !== 1'b1) begin miscompares++; $display("FAIL restart_running: got %b want 1", run3); end
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      vectors++;
      if (cnt3 !== 16'd0) begin miscompares++; $display("FAIL restart_count: got %0d want 0", cnt3); end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_plain();
      test_load();
      test_branch();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_fetch_sequencer

`default_nettype wire
